// File: rtl/instr_fetch_queue.sv
// Fetch/decode decoupling queue: pairs each issued PC with the ROM word returned one
// cycle later, buffers the pairs for decode, and throttles fetch by credit.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pc_if,
    input  logic                     fetch_req,
    input  logic [WIDTH-1:0]         instr_rom,
    output logic                     fetch_en,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [WIDTH-1:0]         pc_id,
    output logic [WIDTH-1:0]         instr_id,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic             r_inflight_v;
    logic [WIDTH-1:0] r_inflight_pc;
    logic [WIDTH-1:0] r_mem_pc  [DEPTH];
    logic [WIDTH-1:0] r_mem_ins [DEPTH];

    logic [CW-1:0] w_occ;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    // Credit counts the in-flight fetch so its returning word always has a slot.
    assign w_occ    = r_count + CW'(r_inflight_v);
    assign fetch_en = rst & (w_occ < DEPTH_C);
    assign w_accept = fetch_req & fetch_en & ~flush;
    assign w_push   = rst & r_inflight_v & ~flush;
    assign w_pop    = id_valid & id_ready & ~flush;

    assign id_valid = (r_count != '0);
    assign count    = r_count;
    assign pc_id    = id_valid ? r_mem_pc[r_head]  : '0;
    assign instr_id = id_valid ? r_mem_ins[r_head] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
        end else if (flush) begin
            r_count      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_inflight_v <= 1'b0;
        end else begin
            r_inflight_v <= w_accept;
            if (w_accept) r_inflight_pc <= pc_if;
            if (w_push)   r_tail <= r_tail + 1'b1;
            if (w_pop)    r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: reads are masked by id_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_tail]  <= r_inflight_pc;
            r_mem_ins[r_tail] <= instr_rom;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) assert (r_count != DEPTH_C) else $error("instr_fetch_queue overflow");
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: vector table for streaming/backpressure,
// hand sequences for reset, flush and mid-stream reset corners.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_if;
    logic        fetch_req;
    logic [31:0] instr_rom;
    logic        fetch_en;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic [2:0]  count;

    int n_run  = 0;
    int n_fail = 0;

    instr_fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .fetch_req(fetch_req),
        .instr_rom(instr_rom), .fetch_en(fetch_en), .flush(flush),
        .id_ready(id_ready), .id_valid(id_valid), .pc_id(pc_id),
        .instr_id(instr_id), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic        req;
        logic [31:0] pc;
        logic [31:0] rom;
        logic        rdy;
        logic        fl;
        logic        e_en;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic en, input logic vld,
                           input logic [31:0] pc, input logic [31:0] ins, input logic [2:0] cnt);
        chk({nm, ".fetch_en"}, {31'd0, fetch_en}, {31'd0, en});
        chk({nm, ".id_valid"}, {31'd0, id_valid}, {31'd0, vld});
        chk({nm, ".pc_id"},    pc_id, pc);
        chk({nm, ".instr_id"}, instr_id, ins);
        chk({nm, ".count"},    {29'd0, count}, {29'd0, cnt});
    endtask

    task automatic drive(input logic rs, input logic req, input logic [31:0] pc,
                         input logic [31:0] rom, input logic rdy, input logic fl);
        rst = rs; fetch_req = req; pc_if = pc; instr_rom = rom; id_ready = rdy; flush = fl;
    endtask

    initial begin
        //              rs  req pc          rom           rdy fl  en  vld pc_id       instr_id      cnt
        // Streaming with decode always ready
        tbl[0]  = '{1'b1,1'b1,32'h00,32'h0,         1'b1,1'b0,1'b1,1'b0,32'h00,32'h0,         3'd0};
        tbl[1]  = '{1'b1,1'b1,32'h04,32'h2000_0000,1'b1,1'b0,1'b1,1'b1,32'h00,32'h2000_0000,3'd1};
        tbl[2]  = '{1'b1,1'b1,32'h08,32'h2000_0004,1'b1,1'b0,1'b1,1'b1,32'h04,32'h2000_0004,3'd1};
        tbl[3]  = '{1'b1,1'b1,32'h0C,32'h2000_0008,1'b1,1'b0,1'b1,1'b1,32'h08,32'h2000_0008,3'd1};
        tbl[4]  = '{1'b1,1'b0,32'h10,32'h2000_000C,1'b1,1'b0,1'b1,1'b1,32'h0C,32'h2000_000C,3'd1};
        tbl[5]  = '{1'b1,1'b0,32'h00,32'h0,         1'b1,1'b0,1'b1,1'b0,32'h00,32'h0,         3'd0};
        tbl[6]  = '{1'b0,1'b1,32'h00,32'h0,         1'b1,1'b0,1'b0,1'b0,32'h00,32'h0,         3'd0};
        // Backpressure: fill to DEPTH, then drain in order
        tbl[7]  = '{1'b1,1'b1,32'h00,32'h0,         1'b0,1'b0,1'b1,1'b0,32'h00,32'h0,         3'd0};
        tbl[8]  = '{1'b1,1'b1,32'h04,32'h2000_0000,1'b0,1'b0,1'b1,1'b1,32'h00,32'h2000_0000,3'd1};
        tbl[9]  = '{1'b1,1'b1,32'h08,32'h2000_0004,1'b0,1'b0,1'b1,1'b1,32'h00,32'h2000_0000,3'd2};
        tbl[10] = '{1'b1,1'b1,32'h0C,32'h2000_0008,1'b0,1'b0,1'b0,1'b1,32'h00,32'h2000_0000,3'd3};
        tbl[11] = '{1'b1,1'b1,32'h10,32'h2000_000C,1'b0,1'b0,1'b0,1'b1,32'h00,32'h2000_0000,3'd4};
        tbl[12] = '{1'b1,1'b1,32'h10,32'h0,         1'b0,1'b0,1'b0,1'b1,32'h00,32'h2000_0000,3'd4};
        tbl[13] = '{1'b1,1'b0,32'h00,32'h0,         1'b1,1'b0,1'b1,1'b1,32'h04,32'h2000_0004,3'd3};
        tbl[14] = '{1'b1,1'b0,32'h00,32'h0,         1'b1,1'b0,1'b1,1'b1,32'h08,32'h2000_0008,3'd2};
        tbl[15] = '{1'b1,1'b0,32'h00,32'h0,         1'b1,1'b0,1'b1,1'b1,32'h0C,32'h2000_000C,3'd1};
        tbl[16] = '{1'b1,1'b0,32'h00,32'h0,         1'b1,1'b0,1'b1,1'b0,32'h00,32'h0,         3'd0};

        // Reset held with fetch_req asserted
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("reset%0d", i), 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        end
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("reset_release.fetch_en", {31'd0, fetch_en}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rs, tbl[i].req, tbl[i].pc, tbl[i].rom, tbl[i].rdy, tbl[i].fl);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_vld, tbl[i].e_pc,
                    tbl[i].e_ins, tbl[i].e_cnt);
        end

        // Flush drops the in-flight fetch; next fetch arrives cleanly
        drive(1'b1, 1'b1, 32'h08, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h2000_0008, 1'b1, 1'b1);
        tick();
        chk_all("flush_inflight.n2", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        chk_all("flush_inflight.n3", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 1'b0, 32'h0, 32'h2000_0040, 1'b1, 1'b0);
        tick();
        chk_all("flush_inflight.n4", 1'b1, 1'b1, 32'h40, 32'h2000_0040, 3'd1);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_all("flush_inflight.drain", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        // Flush coinciding with fetch_req and id_ready at count=2
        drive(1'b1, 1'b1, 32'h00, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h04, 32'h2000_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h2000_0004, 1'b0, 1'b0);
        tick();
        chk_all("flush_same.pre", 1'b1, 1'b1, 32'h00, 32'h2000_0000, 3'd2);
        drive(1'b1, 1'b1, 32'h08, 32'h0, 1'b1, 1'b1);
        tick();
        chk_all("flush_same.post", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 1'b0, 32'h0, 32'h2000_0008, 1'b1, 1'b0);
        tick();
        chk_all("flush_same.empty_pop", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        // Reset mid-stream with count=3 and a fetch in flight
        drive(1'b1, 1'b1, 32'h00, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h04, 32'h2000_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h08, 32'h2000_0004, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0C, 32'h2000_0008, 1'b0, 1'b0);
        tick();
        chk_all("rst_mid.pre", 1'b0, 1'b1, 32'h00, 32'h2000_0000, 3'd3);
        drive(1'b0, 1'b0, 32'h0, 32'h2000_000C, 1'b0, 1'b0);
        tick();
        chk_all("rst_mid.in", 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        drive(1'b1, 1'b0, 32'h0, 32'h2000_000C, 1'b1, 1'b0);
        tick();
        chk_all("rst_mid.post", 1'b1, 1'b0, 32'h0, 32'h0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
